max_abs_seq_unit: RTL and testbench
===================================

// Module: max_abs_seq_unit
// PURPOSE
//   Parametrised, sequential successor to the combinational 3x4-bit max-absolute-value circuit.
//   Accepts one vector of CHANNELS signed WIDTH-bit samples per transaction over a valid/ready handshake.
//   Scans the channels one per clock and returns the winning value, its channel index and a tie flag.
//   The comparison mode is selectable per transaction: max|x|, min|x|, signed max or signed min.
//   Sits between the sample-capture memory path and downstream decision logic.
// PARAMETERS
//   WIDTH    4   bits per channel sample, two's complement, >=2
//   CHANNELS 3   channels per transaction, >=1
//   IDX_W    2   width of out_index, >= max(1, clog2(CHANNELS))
//   CNT_W    16  width of the result counter
// PORTS
//   clk           in   1               single system clock, rising edge
//   global_reset  in   1               asynchronous, active-high reset
//   in_valid      in   1               in_data/in_mode valid
//   in_ready      out  1               unit can accept a transaction
//   in_data       in   CHANNELS*WIDTH  channel k = in_data[k*WIDTH +: WIDTH]
//   in_mode       in   2               00 max|x|, 01 min|x|, 10 signed max, 11 signed min
//   out_valid     out  1               result valid
//   out_ready     in   1               consumer accepts result
//   out_value     out  WIDTH           |x| as unsigned (modes 0x) or raw signed x (modes 1x)
//   out_index     out  IDX_W           channel number of the winner
//   out_tie       out  1               another channel has a key equal to the winner's key
//   result_count  out  CNT_W           number of completed output handshakes, wraps modulo 2^CNT_W
// BEHAVIOUR
//   Reset (async): state IDLE; out_valid, out_value, out_index, out_tie and result_count = 0.
//     in_ready = 0 while global_reset is high.
//   Reset mid-operation: abandons the transaction; no result is produced.
//   The FSM has three states: IDLE, SCAN, DONE.
//   IDLE: in_ready=1.
//     On in_valid & in_ready, capture in_data and in_mode.
//     Load best=key(ch0), idx=0, tie=0, cnt=1.
//     Next state is SCAN, or DONE when CHANNELS==1.
//   SCAN: in_ready=0. Each cycle compares channel cnt against best, then cnt++.
//     After channel CHANNELS-1 is compared, go to DONE.
//   Latency: for an accept at edge 0, out_valid rises after edge CHANNELS-1.
//     This is one cycle minimum.
//   DONE: out_valid=1 and in_ready=0. Outputs hold stable until out_ready.
//     On out_valid & out_ready: result_count++, out_valid drops, and the next state is IDLE.
//     in_ready is high in the following cycle; there is no same-cycle re-accept.
//   Key for modes 0x: |x| = two's-complement negate if the MSB is set, taken modulo 2^WIDTH as unsigned.
//     The most negative value -2^(WIDTH-1) maps to 2^(WIDTH-1), which is representable.
//   Key for modes 1x: x compared as signed.
//   Winner update: only on a strictly better key (greater for x0, smaller for x1). Ties keep the lowest index.
//     An equal key sets tie=1.
//     A strictly better key replaces best and idx, and clears tie.
//   Changes to in_data or in_mode after acceptance have no effect.
//   in_valid outside IDLE is ignored; no queueing.
//   out_ready while out_valid=0 has no effect.
//   out_value, out_index and out_tie change only on the transition into DONE.
// TESTING
//   1 W4,C3, mode 00, ch={3,-7,5}: out_value=7, index=1, tie=0; out_valid rises 2 edges after accept.
//   2 Mode 00, ch={-8,7,-1}: out_value=4'b1000 (8), index=0, tie=0.
//   3 ch={-5,5,2}: mode 00 gives value=5, index=0, tie=1. Mode 10 gives value=5, index=1, tie=0.
//   4 Mode 01, ch={-3,0,1}: value=0, index=1. Mode 11, ch={2,-8,-8}: value=-8 (4'b1000), index=1, tie=1.
//   5 Hold out_ready=0 for 5 cycles, with in_valid=1 and new data:
//     outputs stay stable and in_ready=0. After the handshake, result_count=1 and in_ready=1 next cycle.
//   6 Assert global_reset during SCAN: out_valid=0 and in_ready=0 at once with no clock.
//     After release, IDLE and result_count=0. CHANNELS=1 build: out_valid is high 1 cycle after accept.

Source files
------------

// File: rtl/max_abs_seq_unit_if.sv
// Handshake bundle for max_abs_seq_unit: request vector/mode in, winning value/index/tie out.
interface max_abs_seq_unit_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 3,
  parameter int IDX_W    = 2,
  parameter int CNT_W    = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [1:0]                in_mode;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_value;
  logic [IDX_W-1:0]          out_index;
  logic                      out_tie;
  logic [CNT_W-1:0]          result_count;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_value, out_index, out_tie, result_count
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_value, out_index, out_tie, result_count
  );
endinterface

// File: rtl/max_abs_seq_unit.sv
// Sequential max/min |x| or signed max/min selector: one channel compared per clock,
// result held in DONE until the consumer takes it.
module max_abs_seq_key #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic             i_signed,
  output logic [WIDTH:0]   o_key
);
  logic [WIDTH-1:0] w_abs;

  // One extra bit lets |x| (unsigned, up to 2^(WIDTH-1)) and signed x share a signed compare.
  assign w_abs = i_x[WIDTH-1] ? (~i_x + WIDTH'(1)) : i_x;
  assign o_key = i_signed ? {i_x[WIDTH-1], i_x} : {1'b0, w_abs};
endmodule

module max_abs_seq_unit #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 3,
  parameter int IDX_W    = 2,
  parameter int CNT_W    = 16
) (
  input logic clk,
  input logic global_reset,
  max_abs_seq_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam state_t FIRST = (CHANNELS == 1) ? DONE : SCAN;

  state_t                          r_state, w_next;
  logic [CHANNELS*WIDTH-1:0]       r_data;
  logic [1:0]                      r_mode;
  logic [WIDTH:0]                  r_best;
  logic [IDX_W-1:0]                r_idx, r_cnt;
  logic                            r_tie;
  logic [WIDTH-1:0]                r_out_value;
  logic [IDX_W-1:0]                r_out_index;
  logic                            r_out_tie;
  logic [CNT_W-1:0]                r_count;

  logic [CHANNELS-1:0][WIDTH:0]    w_keys;
  logic [WIDTH:0]                  w_key0_in, w_cur, w_nbest;
  logic [IDX_W-1:0]                w_nidx;
  logic                            w_ntie, w_better, w_equal, w_last, w_accept, w_out_hs;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    max_abs_seq_key #(.WIDTH(WIDTH)) u_key (
      .i_x      (r_data[g*WIDTH +: WIDTH]),
      .i_signed (r_mode[1]),
      .o_key    (w_keys[g])
    );
  end

  max_abs_seq_key #(.WIDTH(WIDTH)) u_key_in (
    .i_x      (bus.in_data[WIDTH-1:0]),
    .i_signed (bus.in_mode[1]),
    .o_key    (w_key0_in)
  );

  assign bus.in_ready     = (r_state == IDLE) && !global_reset;
  assign bus.out_valid    = (r_state == DONE);
  assign bus.out_value    = r_out_value;
  assign bus.out_index    = r_out_index;
  assign bus.out_tie      = r_out_tie;
  assign bus.result_count = r_count;

  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_out_hs = bus.out_valid && bus.out_ready;
  assign w_last   = (r_cnt == IDX_W'(CHANNELS - 1));

  always_comb begin
    w_cur = w_keys[0];
    for (int k = 1; k < CHANNELS; k++)
      if (r_cnt == IDX_W'(k)) w_cur = w_keys[k];
  end

  // Mode bit 0 flips the sense: x0 keeps the larger key, x1 the smaller.
  assign w_better = r_mode[0] ? ($signed(w_cur) < $signed(r_best))
                              : ($signed(w_cur) > $signed(r_best));
  assign w_equal  = (w_cur == r_best);

  always_comb begin
    w_nbest = r_best;
    w_nidx  = r_idx;
    w_ntie  = r_tie;
    if (w_better) begin
      w_nbest = w_cur;
      w_nidx  = r_cnt;
      w_ntie  = 1'b0;
    end else if (w_equal) begin
      w_ntie  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) r_state <= IDLE;
    else              r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = FIRST;
      SCAN:    if (w_last)   w_next = DONE;
      DONE:    if (w_out_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      r_data      <= '0;
      r_mode      <= '0;
      r_best      <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_tie       <= 1'b0;
      r_out_value <= '0;
      r_out_index <= '0;
      r_out_tie   <= 1'b0;
      r_count     <= '0;
    end else begin
      if (w_accept) begin
        r_data <= bus.in_data;
        r_mode <= bus.in_mode;
        r_best <= w_key0_in;
        r_idx  <= '0;
        r_tie  <= 1'b0;
        r_cnt  <= IDX_W'(1);
        if (CHANNELS == 1) begin
          r_out_value <= w_key0_in[WIDTH-1:0];
          r_out_index <= '0;
          r_out_tie   <= 1'b0;
        end
      end
      if (r_state == SCAN) begin
        r_best <= w_nbest;
        r_idx  <= w_nidx;
        r_tie  <= w_ntie;
        r_cnt  <= r_cnt + IDX_W'(1);
        if (w_last) begin
          r_out_value <= w_nbest[WIDTH-1:0];
          r_out_index <= w_nidx;
          r_out_tie   <= w_ntie;
        end
      end
      if (w_out_hs) r_count <= r_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_max_abs_seq_unit.sv
// Directed bench for max_abs_seq_unit: a 3-channel and a 1-channel instance, scoreboard-checked.
module tb_max_abs_seq_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  max_abs_seq_unit_if #(.WIDTH(4), .CHANNELS(3), .IDX_W(2), .CNT_W(16)) bus  ();
  max_abs_seq_unit_if #(.WIDTH(4), .CHANNELS(1), .IDX_W(1), .CNT_W(16)) bus1 ();

  max_abs_seq_unit #(.WIDTH(4), .CHANNELS(3), .IDX_W(2), .CNT_W(16)) dut (
    .clk(clk), .global_reset(rst), .bus(bus.slave));
  max_abs_seq_unit #(.WIDTH(4), .CHANNELS(1), .IDX_W(1), .CNT_W(16)) dut1 (
    .clk(clk), .global_reset(rst), .bus(bus1.slave));

  typedef struct packed {
    logic [3:0] v;
    logic [1:0] i;
    logic       t;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned exp_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Accept one vector on the 3-channel unit, then check latency and the popped expectation.
  task automatic send3(input logic [11:0] d, input logic [1:0] m, input exp_t e);
    int   n;
    exp_t x;
    sb.push_back(e);
    n = 0;
    while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
    chk("in_ready_wait", 32'(bus.in_ready), 1);
    bus.in_data  = d;
    bus.in_mode  = m;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = ~d;
    bus.in_mode  = ~m;
    n = 0;
    while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
    chk("latency", n, 2);
    x = sb.pop_front();
    chk("value", 32'(bus.out_value), 32'(x.v));
    chk("index", 32'(bus.out_index), 32'(x.i));
    chk("tie",   32'(bus.out_tie),   32'(x.t));
  endtask

  task automatic drain3;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    exp_cnt++;
    chk("valid_drop", 32'(bus.out_valid), 0);
    chk("count", 32'(bus.result_count), exp_cnt);
    chk("in_ready_next", 32'(bus.in_ready), 1);
  endtask

  initial begin
    logic [3:0]  hv;
    logic [1:0]  hi;
    logic        ht;
    exp_t        x;
    bus.in_valid  = 1'b0; bus.in_data  = '0; bus.in_mode  = '0; bus.out_ready  = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_mode = '0; bus1.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_in_ready",  32'(bus.in_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_count",     32'(bus.result_count), 0);
    chk("rst_value",     32'(bus.out_value), 0);
    chk("rst_index",     32'(bus.out_index), 0);
    chk("rst_tie",       32'(bus.out_tie), 0);
    rst = 1'b0;
    @(negedge clk);

    // ch2,ch1,ch0 packed high to low
    send3({4'd5, 4'h9, 4'd3}, 2'b00, exp_t'{4'd7, 2'd1, 1'b0}); drain3();
    send3({4'hF, 4'h7, 4'h8}, 2'b00, exp_t'{4'd8, 2'd0, 1'b0}); drain3();
    send3({4'h2, 4'h5, 4'hB}, 2'b00, exp_t'{4'd5, 2'd0, 1'b1}); drain3();
    send3({4'h2, 4'h5, 4'hB}, 2'b10, exp_t'{4'd5, 2'd1, 1'b0}); drain3();
    send3({4'h1, 4'h0, 4'hD}, 2'b01, exp_t'{4'd0, 2'd1, 1'b0}); drain3();
    send3({4'h8, 4'h8, 4'h2}, 2'b11, exp_t'{4'h8, 2'd1, 1'b1}); drain3();
    send3({4'h7, 4'h9, 4'h7}, 2'b00, exp_t'{4'd7, 2'd0, 1'b1}); drain3();

    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("idle_out_ready", 32'(bus.result_count), exp_cnt);

    // Backpressure: result must hold while new requests are offered and refused
    send3({4'd5, 4'h9, 4'd3}, 2'b00, exp_t'{4'd7, 2'd1, 1'b0});
    hv = bus.out_value; hi = bus.out_index; ht = bus.out_tie;
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 12'($urandom);
      bus.in_mode  = 2'($urandom);
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 1);
      chk("hold_ready", 32'(bus.in_ready), 0);
      chk("hold_value", 32'(bus.out_value), 32'(hv));
      chk("hold_index", 32'(bus.out_index), 32'(hi));
      chk("hold_tie",   32'(bus.out_tie), 32'(ht));
    end
    bus.in_valid = 1'b0;
    drain3();

    // Reset while scanning abandons the transaction
    bus.in_data = {4'd1, 4'd2, 4'd3}; bus.in_mode = 2'b00; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_ready", 32'(bus.in_ready), 0);
    chk("mid_rst_count", 32'(bus.result_count), 0);
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.in_ready), 1);
    repeat (4) @(negedge clk);
    chk("post_rst_no_result", 32'(bus.out_valid), 0);

    // Single-channel build: result valid right after the accepting edge
    sb.push_back(exp_t'{4'h8, 2'd0, 1'b0});
    bus1.in_data = 4'h8; bus1.in_mode = 2'b00; bus1.in_valid = 1'b1;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    chk("c1_latency", 32'(bus1.out_valid), 1);
    x = sb.pop_front();
    chk("c1_value", 32'(bus1.out_value), 32'(x.v));
    chk("c1_index", 32'(bus1.out_index), 32'(x.i));
    chk("c1_tie",   32'(bus1.out_tie), 32'(x.t));
    bus1.out_ready = 1'b1;
    @(negedge clk);
    bus1.out_ready = 1'b0;
    chk("c1_count", 32'(bus1.result_count), 1);
    sb.push_back(exp_t'{4'hD, 2'd0, 1'b0});
    bus1.in_data = 4'hD; bus1.in_mode = 2'b11; bus1.in_valid = 1'b1;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    chk("c1_latency2", 32'(bus1.out_valid), 1);
    x = sb.pop_front();
    chk("c1_value2", 32'(bus1.out_value), 32'(x.v));

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
